// File: rtl/collatz_pkg.sv
// Shared types and widths for the Collatz range sweep.
// Holds the sweep FSM state enum and datapath widths.
package collatz_pkg;

  localparam int N_W = 32;
  localparam int COUNT_W = 16;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/collatz_range_sweep_if.sv
// Control/result bundle for the Collatz range sweep.
// go/start in (n0 or read address), done/count out.
interface collatz_range_sweep_if;
  import collatz_pkg::*;

  logic               go;
  logic [N_W-1:0]     start;
  logic               done;
  logic [COUNT_W-1:0] count;

  modport master (
    output go, start,
    input  done, count
  );

  modport slave (
    input  go, start,
    output done, count
  );

endinterface

// File: rtl/collatz.sv
// Collatz iteration engine: one step per clock.
// go loads n; done while value==1 or n was 0.
module collatz
  import collatz_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [N_W-1:0]     n,
  output logic [COUNT_W-1:0] dout,
  output logic               done
);

  logic [N_W-1:0] cur;
  logic           zero;

  assign done = zero || (cur == N_W'(1));

  // dout counts sequence values seen so far,
  // so a loaded value already counts as one.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur  <= N_W'(1);
      zero <= 1'b0;
      dout <= '0;
    end else if (go) begin
      cur  <= n;
      zero <= (n == '0);
      dout <= (n == '0) ? '0 : COUNT_W'(1);
    end else if (!done) begin
      cur <= cur[0] ? (cur * N_W'(3) + N_W'(1))
                    : (cur >> 1);
      if (dout != COUNT_MAX)
        dout <= dout + 1'b1;
    end
  end

endmodule

// File: rtl/collatz_range_sweep.sv
// Sweeps RAM_WORDS start values through the engine into RAM.
// Ports: clk, reset, bus (go/start in, done/count out).
module collatz_range_sweep
  import collatz_pkg::*;
#(
  parameter int RAM_WORDS     = 256,
  parameter int RAM_ADDR_BITS = 8
) (
  input logic                  clk,
  input logic                  reset,
  collatz_range_sweep_if.slave bus
);

  state_t state, state_nx;

  logic [N_W-1:0]           n0;
  logic [RAM_ADDR_BITS-1:0] idx;
  logic [RAM_ADDR_BITS-1:0] addr;
  logic                     last;
  logic                     launch;
  logic                     eng_done;
  logic [COUNT_W-1:0]       eng_cnt;
  logic [COUNT_W-1:0]       mem [RAM_WORDS];

  assign addr   = bus.start[RAM_ADDR_BITS-1:0];
  assign last   = idx == RAM_ADDR_BITS'(RAM_WORDS - 1);
  assign launch = (state == IDLE || state == DONE)
               && bus.go;
  assign bus.done = state == DONE;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (bus.go) state_nx = LOAD;
      LOAD:       state_nx = RUN;
      RUN:        if (eng_done) state_nx = WRITE;
      WRITE:      state_nx = last ? DONE : LOAD;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n0  <= '0;
      idx <= '0;
    end else if (launch) begin
      n0  <= bus.start;
      idx <= '0;
    end else if (state == WRITE && !last) begin
      idx <= idx + 1'b1;
    end
  end

  collatz u_eng (
    .clk   (clk),
    .reset (reset),
    .go    (state == LOAD),
    .n     (n0 + N_W'(idx)),
    .dout  (eng_cnt),
    .done  (eng_done)
  );

  // Result RAM has no reset; it is only read after a full sweep.
  always_ff @(posedge clk) begin
    if (state == WRITE)
      mem[idx] <= eng_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset)
      bus.count <= '0;
    else if (state == DONE)
      bus.count <= (int'(addr) < RAM_WORDS) ? mem[addr] : '0;
  end

endmodule
